// File: rtl/pixel_pkg.sv
// Shared definitions for the CVM300 pixel packer: capture FSM states and
// byte-lane geometry of the 32-bit packed word.
package pixel_pkg;

   localparam int unsigned LANES   = 4;
   localparam int unsigned LANE_W  = 8;
   localparam int unsigned WORD_W  = LANES * LANE_W;
   localparam int unsigned LANE_IW = $clog2(LANES);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ARMED,
      ST_CAPTURE,
      ST_FLUSH,
      ST_DONE
   } state_t;

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO for packed pixel words; head word is driven
// combinationally from storage, level saturates at 2**AW.
module sync_fifo
   import pixel_pkg::*;
#(
   parameter int unsigned AW = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_wr_en,
   input  logic [WORD_W-1:0] i_wr_data,
   input  logic              i_rd_en,
   output logic [WORD_W-1:0] o_rd_data,
   output logic              o_empty,
   output logic              o_full,
   output logic [AW:0]       o_level
);

   localparam int unsigned DEPTH = 2 ** AW;

   logic [WORD_W-1:0] r_mem [DEPTH];
   logic [AW-1:0]     r_wr_ptr;
   logic [AW-1:0]     r_rd_ptr;
   logic [AW:0]       r_count;
   logic              w_do_rd;
   logic              w_do_wr;

   // Count never exceeds DEPTH, so its MSB alone marks full.
   assign o_full    = r_count[AW];
   assign o_empty   = (r_count == '0);
   assign o_level   = r_count;
   assign o_rd_data = r_mem[r_rd_ptr];

   assign w_do_rd = i_rd_en & ~o_empty;
   assign w_do_wr = i_wr_en & (~o_full | w_do_rd);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (w_do_wr) begin
         r_mem[r_wr_ptr] <= i_wr_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_wr) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_do_rd) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_do_wr, w_do_rd})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/pixel_packer.sv
// Captures one CVM300 frame per arm request, packs the upper 8 bits of four
// pixels into each 32-bit word and queues the words for the pipe reader.
module pixel_packer
   import pixel_pkg::*;
#(
   parameter int unsigned FIFO_AW = 4,
   parameter int unsigned PIX_W   = 10
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [PIX_W-1:0]   pix_data,
   input  logic               pix_fval,
   input  logic               pix_lval,
   input  logic               pix_dval,
   input  logic               arm,
   input  logic               rd_en,
   output logic [WORD_W-1:0]  dout,
   output logic               empty,
   output logic [FIFO_AW:0]   level,
   output logic               busy,
   output logic               frame_done,
   output logic               overflow
);

   state_t              r_state;
   logic                r_fval_d;
   logic [LANE_IW-1:0]  r_lane;
   logic [WORD_W-1:0]   r_pack;
   logic [WORD_W-1:0]   r_push_word;
   logic                r_push;
   logic                r_busy;
   logic                r_frame_done;
   logic                r_overflow;

   logic                w_pix_ok;
   logic [LANE_W-1:0]   w_byte;
   logic                w_fval_rise;
   logic                w_fval_fall;
   logic                w_full;
   logic                w_drop;

   assign w_byte      = pix_data[PIX_W-1 -: LANE_W];
   assign w_pix_ok    = pix_fval & pix_lval & pix_dval;
   assign w_fval_rise = pix_fval & ~r_fval_d;
   assign w_fval_fall = ~pix_fval & r_fval_d;
   assign w_drop      = r_push & w_full & ~rd_en;

   generate
      if (PIX_W > LANE_W) begin : g_lsb
         logic w_unused_lsbs;
         assign w_unused_lsbs = ^pix_data[PIX_W-LANE_W-1:0];
      end
   endgenerate

   assign busy       = r_busy;
   assign frame_done = r_frame_done;
   assign overflow   = r_overflow;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_fval_d     <= 1'b0;
         r_lane       <= '0;
         r_pack       <= '0;
         r_push_word  <= '0;
         r_push       <= 1'b0;
         r_busy       <= 1'b0;
         r_frame_done <= 1'b0;
         r_overflow   <= 1'b0;
      end else begin
         r_fval_d <= pix_fval;
         r_push   <= 1'b0;

         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (arm) begin
                  r_state      <= ST_ARMED;
                  r_busy       <= 1'b1;
                  r_frame_done <= 1'b0;
                  r_overflow   <= 1'b0;
               end
            end

            // Only a fresh 0->1 fval edge starts capture, so a frame already
            // running when arm arrived is skipped entirely.
            ST_ARMED: begin
               if (w_fval_rise) begin
                  r_state <= ST_CAPTURE;
               end
            end

            ST_CAPTURE: begin
               if (w_fval_fall) begin
                  r_state <= ST_FLUSH;
               end else if (w_pix_ok) begin
                  if (r_lane == LANE_IW'(LANES - 1)) begin
                     r_push_word <= {w_byte, r_pack[WORD_W-LANE_W-1:0]};
                     r_push      <= 1'b1;
                     r_pack      <= '0;
                     r_lane      <= '0;
                  end else begin
                     r_pack[r_lane*LANE_W +: LANE_W] <= w_byte;
                     r_lane <= r_lane + 1'b1;
                  end
               end
            end

            ST_FLUSH: begin
               if (r_lane != '0) begin
                  r_push_word <= r_pack;
                  r_push      <= 1'b1;
               end
               r_pack       <= '0;
               r_lane       <= '0;
               r_state      <= ST_DONE;
               r_busy       <= 1'b0;
               r_frame_done <= 1'b1;
            end

            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase

         // A drop in the same cycle as an accepted arm must stay visible.
         if (w_drop) begin
            r_overflow <= 1'b1;
         end
      end
   end

   sync_fifo #(
      .AW (FIFO_AW)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .i_wr_en   (r_push),
      .i_wr_data (r_push_word),
      .i_rd_en   (rd_en),
      .o_rd_data (dout),
      .o_empty   (empty),
      .o_full    (w_full),
      .o_level   (level)
   );

endmodule

// File: tb/tb_pixel_packer.sv
// Directed bench for pixel_packer: frame capture, partial flush, skipped
// frame, overflow, simultaneous push/pop and mid-frame reset.
module tb_pixel_packer;

   localparam int unsigned AW = 4;
   localparam int unsigned PW = 10;

   logic            clk = 1'b0;
   logic            rst;
   logic [PW-1:0]   pix_data;
   logic            pix_fval;
   logic            pix_lval;
   logic            pix_dval;
   logic            arm;
   logic            rd_en;
   logic [31:0]     dout;
   logic            empty;
   logic [AW:0]     level;
   logic            busy;
   logic            frame_done;
   logic            overflow;

   int checks = 0;
   int errors = 0;

   logic [PW-1:0] fdat [0:127];
   logic [31:0]   exp_w [0:3];

   always #5 clk = ~clk;

   pixel_packer #(
      .FIFO_AW (AW),
      .PIX_W   (PW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .pix_data   (pix_data),
      .pix_fval   (pix_fval),
      .pix_lval   (pix_lval),
      .pix_dval   (pix_dval),
      .arm        (arm),
      .rd_en      (rd_en),
      .dout       (dout),
      .empty      (empty),
      .level      (level),
      .busy       (busy),
      .frame_done (frame_done),
      .overflow   (overflow)
   );

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic pulse_arm();
      arm = 1'b1;
      tick();
      arm = 1'b0;
   endtask

   task automatic pop();
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
   endtask

   task automatic send_line(input int start, input int n);
      pix_lval = 1'b1;
      for (int i = 0; i < n; i++) begin
         pix_data = fdat[start + i];
         pix_dval = 1'b1;
         tick();
      end
      pix_dval = 1'b0;
      pix_lval = 1'b0;
      tick();
      tick();
   endtask

   task automatic send_frame(input int n_lines, input int ppl);
      pix_fval = 1'b1;
      tick();
      tick();
      for (int l = 0; l < n_lines; l++) begin
         send_line(l * ppl, ppl);
      end
      pix_fval = 1'b0;
      repeat (4) tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst      = 1'b1;
      pix_data = '0;
      pix_fval = 1'b0;
      pix_lval = 1'b0;
      pix_dval = 1'b0;
      arm      = 1'b0;
      rd_en    = 1'b0;
      tick();
      tick();

      chk("rst_empty",      32'(empty),      32'd1);
      chk("rst_level",      32'(level),      32'd0);
      chk("rst_busy",       32'(busy),       32'd0);
      chk("rst_frame_done", 32'(frame_done), 32'd0);
      chk("rst_overflow",   32'(overflow),   32'd0);
      chk("rst_dout",       dout,            32'h0000_0000);
      rst = 1'b0;
      tick();

      // 2 lines x 8 pixels: 0x3FC, then 4*k
      fdat[0] = 10'h3FC;
      for (int k = 1; k < 16; k++) fdat[k] = 10'(k * 4);
      exp_w[0] = 32'h0302_01FF;
      exp_w[1] = 32'h0706_0504;
      exp_w[2] = 32'h0B0A_0908;
      exp_w[3] = 32'h0F0E_0D0C;
      pulse_arm();
      chk("armed_busy", 32'(busy), 32'd1);
      send_frame(2, 8);
      chk("f1_level",      32'(level),      32'd4);
      chk("f1_frame_done", 32'(frame_done), 32'd1);
      chk("f1_busy",       32'(busy),       32'd0);
      chk("f1_overflow",   32'(overflow),   32'd0);
      for (int w = 0; w < 4; w++) begin
         chk($sformatf("f1_word%0d", w), dout, exp_w[w]);
         pop();
      end
      chk("f1_empty_after", 32'(empty), 32'd1);

      // 6-pixel frame: partial second word flushed with zero upper lanes
      fdat[0] = 10'h100;
      fdat[1] = 10'h10C;
      fdat[2] = 10'h118;
      fdat[3] = 10'h124;
      fdat[4] = 10'h130;
      fdat[5] = 10'h140;
      pulse_arm();
      chk("f2_done_cleared", 32'(frame_done), 32'd0);
      send_frame(1, 6);
      chk("f2_level",      32'(level),      32'd2);
      chk("f2_frame_done", 32'(frame_done), 32'd1);
      chk("f2_word0", dout, 32'h4946_4340);
      pop();
      chk("f2_word1", dout, 32'h0000_504C);
      pop();

      // arm during an active frame: that frame is skipped
      fdat[0] = 10'h3FC;
      fdat[1] = 10'h004;
      fdat[2] = 10'h008;
      fdat[3] = 10'h00C;
      pix_fval = 1'b1;
      tick();
      tick();
      pulse_arm();
      send_line(0, 4);
      pix_fval = 1'b0;
      tick();
      tick();
      chk("skip_level", 32'(level), 32'd0);
      chk("skip_busy",  32'(busy),  32'd1);
      send_frame(1, 4);
      chk("next_level", 32'(level),      32'd1);
      chk("next_done",  32'(frame_done), 32'd1);
      chk("next_word",  dout,            32'h0302_01FF);
      pop();

      // 20-word frame into a 16-deep FIFO with no reads
      for (int k = 0; k < 80; k++) fdat[k] = 10'(k * 4);
      pulse_arm();
      send_frame(1, 80);
      chk("ovf_level",    32'(level),    32'd16);
      chk("ovf_overflow", 32'(overflow), 32'd1);
      chk("ovf_empty",    32'(empty),    32'd0);
      for (int w = 0; w < 16; w++) begin
         chk($sformatf("ovf_word%0d", w), dout,
             {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)});
         pop();
      end
      chk("ovf_level_drained", 32'(level), 32'd0);
      chk("ovf_empty_drained", 32'(empty), 32'd1);

      // read while empty: slot 7 still holds the first word of the last frame
      chk("rdempty_dout_before", dout, 32'h0302_0100);
      pop();
      chk("rdempty_level", 32'(level), 32'd0);
      chk("rdempty_empty", 32'(empty), 32'd1);
      chk("rdempty_dout",  dout,       32'h0302_0100);

      // 17th word pushed in the same cycle as a pop at level 16
      pulse_arm();
      chk("pp_overflow_cleared", 32'(overflow), 32'd0);
      pix_fval = 1'b1;
      tick();
      tick();
      pix_lval = 1'b1;
      for (int k = 0; k < 68; k++) begin
         pix_data = fdat[k];
         pix_dval = 1'b1;
         tick();
      end
      pix_dval = 1'b0;
      rd_en    = 1'b1;
      tick();
      rd_en    = 1'b0;
      pix_lval = 1'b0;
      tick();
      chk("pp_level",    32'(level),    32'd16);
      chk("pp_overflow", 32'(overflow), 32'd0);
      chk("pp_head",     dout,          32'h0706_0504);
      pix_fval = 1'b0;
      repeat (4) tick();
      chk("pp_level_end",    32'(level),      32'd16);
      chk("pp_overflow_end", 32'(overflow),   32'd0);
      chk("pp_done",         32'(frame_done), 32'd1);

      // reset two pixels into a capture
      pulse_arm();
      pix_fval = 1'b1;
      tick();
      tick();
      pix_lval = 1'b1;
      for (int k = 0; k < 2; k++) begin
         pix_data = fdat[k];
         pix_dval = 1'b1;
         tick();
      end
      pix_dval = 1'b0;
      rst      = 1'b1;
      tick();
      chk("mrst_level", 32'(level),      32'd0);
      chk("mrst_busy",  32'(busy),       32'd0);
      chk("mrst_empty", 32'(empty),      32'd1);
      chk("mrst_dout",  dout,            32'h0000_0000);
      chk("mrst_done",  32'(frame_done), 32'd0);
      rst      = 1'b0;
      pix_lval = 1'b0;
      pix_fval = 1'b0;
      tick();
      tick();
      send_frame(1, 8);
      chk("noarm_level", 32'(level),      32'd0);
      chk("noarm_busy",  32'(busy),       32'd0);
      chk("noarm_done",  32'(frame_done), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pixel_packer.md
PIXEL_PACKER -- requirements
Module: pixel_packer

Interface
REQ-001 Parameter FIFO_AW, default 4, FIFO address width; depth = 2**FIFO_AW words.
REQ-002 Parameter PIX_W, default 10, sensor pixel width; the upper 8 bits of each pixel are kept.
REQ-003 clk  input  1  system clock; sensor bus, control and pipe side are all in this domain.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 pix_data  input  PIX_W  CVM300 parallel pixel data, sampled on rising clk.
REQ-006 pix_fval  input  1  frame valid.
REQ-007 pix_lval  input  1  line valid.
REQ-008 pix_dval  input  1  data valid; a pixel is accepted only when fval, lval and dval are all 1.
REQ-009 arm  input  1  single-cycle pulse from PC wire logic; requests capture of one frame.
REQ-010 rd_en  input  1  pipe read strobe (driven by okPipeOut ep_read); pops one word.
REQ-011 dout  output  32  FIFO head word (first-word-fall-through) to okPipeOut ep_datain.
REQ-012 empty  output  1  FIFO holds zero words.
REQ-013 level  output  FIFO_AW+1  current FIFO word count.
REQ-014 busy  output  1  high in ARMED, CAPTURE and FLUSH.
REQ-015 frame_done  output  1  sticky; set on entry to DONE, cleared by arm.
REQ-016 overflow  output  1  sticky; set when a word is dropped on full FIFO, cleared by arm.

Function
REQ-017 FSM states: IDLE, ARMED, CAPTURE, FLUSH, DONE.
REQ-018 IDLE -> ARMED on arm; DONE -> ARMED on arm; arm in ARMED/CAPTURE/FLUSH is ignored.
REQ-019 ARMED waits for pix_fval sampled 0 then 1 (rising edge); a frame already in progress at arm time is skipped; on the edge, -> CAPTURE.
REQ-020 CAPTURE: each accepted pixel's bits [PIX_W-1:PIX_W-8] go into byte lane index 0..3 of a pack register; pixel 0 in bits [7:0], pixel 3 in bits [31:24].
REQ-021 When lane 3 is filled, the packed word is pushed into the FIFO in the next cycle (one-cycle latency from 4th pixel to push); the lane index wraps to 0.
REQ-022 Falling edge of pix_fval in CAPTURE -> FLUSH; pixels are not accepted outside CAPTURE.
REQ-023 FLUSH: if lane index is nonzero, the partial word is pushed with unfilled lanes zero; lane index resets to 0; -> DONE in the following cycle.
REQ-024 DONE: frame_done=1, busy=0; FIFO remains readable.
REQ-025 Push when full and no pop in the same cycle: word dropped, overflow set, FIFO unchanged.
REQ-026 Push and pop in the same cycle: both performed, level unchanged, including at full.
REQ-027 rd_en while empty: ignored; dout holds its value; level stays 0.
REQ-028 dout shows the oldest stored word combinationally from FIFO storage; after a pop it shows the next word in the cycle following rd_en.
REQ-029 level saturates at 2**FIFO_AW; read/write pointers wrap modulo depth.
REQ-030 arm clears frame_done and overflow but does not clear FIFO contents.

Reset
REQ-031 rst asserted: FSM to IDLE, FIFO pointers 0, lane index 0, pack register 0, fval history 0.
REQ-032 Outputs under reset: empty=1, level=0, busy=0, frame_done=0, overflow=0, dout=0.
REQ-033 rst mid-frame discards partial word and all FIFO contents; a fresh arm is required afterwards.

Structure
REQ-034 State encoding and the byte-lane count (4) live in a shared package, pixel_pkg.
REQ-035 FIFO is one sub-module, sync_fifo (FWFT, parameter AW, width 32); packing and FSM live in pixel_packer.

Verification
REQ-036 Arm, then frame of 2 lines x 8 pixels with data 0x3FC,0x004,... -> 4 words, first word bytes [7:0]=0xFF, [15:8]=0x01; frame_done=1.
REQ-037 Frame of 6 pixels 0x100..0x140 -> 2 words, second word upper 16 bits 0x0000; frame_done after FLUSH.
REQ-038 Arm while pix_fval=1 -> current frame skipped, next frame captured; level counts only next frame's words.
REQ-039 Depth 16, 20-word frame, no reads -> level=16, overflow=1, words 17..20 lost; reading returns words 1..16 in order.
REQ-040 rd_en with empty=1 -> level stays 0, dout unchanged; simultaneous push/pop at level=16 -> level stays 16, overflow=0.
REQ-041 rst asserted after 2 pixels of CAPTURE -> level=0, busy=0; next frame without arm produces no words.
